ex_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS32 core. It drives the EX stage's operand-forwarding selects and detects load-use hazards, inserting the required bubbles. It also squashes wrong-path instructions on a taken branch and drains the pipeline on HALT, then raises the global `HALTED` flag. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and owns every stall, flush and halt decision in the core.

---
 rtl/ex_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX operand forwarding, load-use interlock, branch flush and
// HALT drain sequencing for the five-stage MIPS32 pipeline.
// Optional feature macro: EX_FORWARDING_EN (forwarding paths present).
// Without it the forward selects are tied to 00 and every RAW on ID/EX or
// EX/MEM is resolved by stalling.
// The IF/ID instruction carries no type code, so both its rs and rt fields
// are treated as sources for hazard detection (conservative).
module ex_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] ID_EX_IR,
  input  logic [2:0]  ID_EX_TYPE,
  input  logic [31:0] EX_MEM_IR,
  input  logic [31:0] MEM_WB_IR,
  input  logic [2:0]  EX_MEM_TYPE,
  input  logic [2:0]  MEM_WB_TYPE,
  input  logic        TAKEN_BRANCH,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        STALL,
  output logic        FLUSH,
  output logic        HALTED
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CNT_W  = 2;

  localparam logic [TYPE_W-1:0] T_RR    = 3'b000;
  localparam logic [TYPE_W-1:0] T_RM    = 3'b001;
  localparam logic [TYPE_W-1:0] T_LOAD  = 3'b010;
  localparam logic [TYPE_W-1:0] T_STORE = 3'b011;
  localparam logic [TYPE_W-1:0] T_HALT  = 3'b101;

  typedef enum logic [1:0] {S_RUN, S_LSTALL, S_DRAIN, S_HALT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_W-1:0] if_rs, if_rt;
  logic [REG_W-1:0] idex_haz_dst, exmem_haz_dst;
  logic [CNT_W-1:0] haz_len;

  // Destination register written by an instruction, r0 when it writes nothing.
  function automatic logic [REG_W-1:0] dest_reg(input logic [31:0] ir,
                                                 input logic [TYPE_W-1:0] t);
    case (t)
      T_RR:         dest_reg = ir[15:11];
      T_RM, T_LOAD: dest_reg = ir[20:16];
      default:      dest_reg = '0;
    endcase
  endfunction

  // True when a real (non-r0) destination feeds either IF/ID source field.
  function automatic logic src_match(input logic [REG_W-1:0] d,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt);
    src_match = (d != '0) && ((d == rs) || (d == rt));
  endfunction

`ifdef EX_FORWARDING_EN
  logic [REG_W-1:0] exmem_alu_dst, memwb_alu_dst;

  function automatic logic alu_writes(input logic [TYPE_W-1:0] t);
    alu_writes = (t == T_RR) || (t == T_RM);
  endfunction

  // EX/MEM beats MEM/WB; r0 or a non-source field never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             used,
                                         input logic [REG_W-1:0] exd,
                                         input logic [REG_W-1:0] mwd);
    if (!used || (src == '0)) fwd_sel = 2'b00;
    else if (exd == src)      fwd_sel = 2'b10;
    else if (mwd == src)      fwd_sel = 2'b01;
    else                      fwd_sel = 2'b00;
  endfunction

  // Zero-latency operand selects for the instruction in EX.
  always_comb begin
    exmem_alu_dst = alu_writes(EX_MEM_TYPE) ? dest_reg(EX_MEM_IR, EX_MEM_TYPE) : '0;
    memwb_alu_dst = alu_writes(MEM_WB_TYPE) ? dest_reg(MEM_WB_IR, MEM_WB_TYPE) : '0;
    ForwardA = fwd_sel(ID_EX_IR[25:21], ID_EX_TYPE != T_HALT,
                       exmem_alu_dst, memwb_alu_dst);
    ForwardB = fwd_sel(ID_EX_IR[20:16], (ID_EX_TYPE == T_RR) || (ID_EX_TYPE == T_STORE),
                       exmem_alu_dst, memwb_alu_dst);
  end

  // Only loads can still hazard once ALU results are forwarded.
  always_comb begin
    idex_haz_dst  = (ID_EX_TYPE  == T_LOAD) ? ID_EX_IR[20:16]  : '0;
    exmem_haz_dst = (EX_MEM_TYPE == T_LOAD) ? EX_MEM_IR[20:16] : '0;
  end
`else
  assign ForwardA = 2'b00;
  assign ForwardB = 2'b00;

  // No bypass: any writer in ID/EX or EX/MEM must be waited out.
  always_comb begin
    idex_haz_dst  = dest_reg(ID_EX_IR, ID_EX_TYPE);
    exmem_haz_dst = dest_reg(EX_MEM_IR, EX_MEM_TYPE);
  end
`endif

  // Hazard length seen by the instruction in ID: 2 from ID/EX, 1 from EX/MEM.
  always_comb begin
    if_rs = IF_ID_IR[25:21];
    if_rt = IF_ID_IR[20:16];
    if (src_match(idex_haz_dst, if_rs, if_rt))       haz_len = 2'd2;
    else if (src_match(exmem_haz_dst, if_rs, if_rt)) haz_len = 2'd1;
    else                                             haz_len = 2'd0;
  end

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and STALL/FLUSH; a taken branch overrides everything but HALT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    STALL   = 1'b0;
    FLUSH   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (TAKEN_BRANCH) begin
          FLUSH = 1'b1;
          cnt_d = '0;
        end else if (ID_EX_TYPE == T_HALT) begin
          STALL = 1'b1;
          if (DRAIN_CYCLES > 1) begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            state_d = S_HALT;
            cnt_d   = '0;
          end
        end else if (haz_len != '0) begin
          STALL = 1'b1;
          cnt_d = haz_len - 2'd1;
          if (haz_len > 2'd1) state_d = S_LSTALL;
        end
      end
      S_LSTALL, S_DRAIN: begin
        if (TAKEN_BRANCH) begin
          FLUSH   = 1'b1;
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          STALL = 1'b1;
          if (cnt_q > 2'd1) begin
            cnt_d = cnt_q - 2'd1;
          end else begin
            cnt_d   = '0;
            state_d = (state_q == S_DRAIN) ? S_HALT : S_RUN;
          end
        end
      end
      S_HALT: begin
        STALL = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign HALTED = (state_q == S_HALT);

  // Opcode, immediate and MEM/WB fields that this block does not decode.
  logic unused_bits;
  assign unused_bits = ^{IF_ID_IR, ID_EX_IR, EX_MEM_IR, MEM_WB_IR, MEM_WB_TYPE};

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Testbench for ex_hazard_ctrl: directed vector table, multi-cycle sequences
// and random stimulus, all checked against a cycle-level reference model.
module tb_ex_hazard_ctrl;

  localparam int unsigned DC = 3;
  localparam logic [2:0] T_RR = 3'd0, T_RM = 3'd1, T_LOAD = 3'd2, T_STORE = 3'd3,
                         T_BR = 3'd4, T_HALT = 3'd5;
`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        tb;
    logic [31:0] ifid;
    logic [31:0] idex;
    logic [31:0] exmem;
    logic [31:0] memwb;
    logic [2:0]  tidex;
    logic [2:0]  texmem;
    logic [2:0]  tmemwb;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_IR, ID_EX_IR, EX_MEM_IR, MEM_WB_IR;
  logic [2:0]  ID_EX_TYPE, EX_MEM_TYPE, MEM_WB_TYPE;
  logic        TAKEN_BRANCH;
  logic [1:0]  ForwardA, ForwardB;
  logic        STALL, FLUSH, HALTED;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_IR(IF_ID_IR), .ID_EX_IR(ID_EX_IR), .ID_EX_TYPE(ID_EX_TYPE),
    .EX_MEM_IR(EX_MEM_IR), .MEM_WB_IR(MEM_WB_IR),
    .EX_MEM_TYPE(EX_MEM_TYPE), .MEM_WB_TYPE(MEM_WB_TYPE),
    .TAKEN_BRANCH(TAKEN_BRANCH),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .STALL(STALL), .FLUSH(FLUSH), .HALTED(HALTED)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: remaining stall cycles, remaining drain cycles, halted flag.
  int stall_left = 0;
  int drain_left = 0;
  bit halted     = 1'b0;

  logic [1:0] a_fa, a_fb;
  logic       a_st, a_fl, a_hl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ir(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic in_t mk(input logic [31:0] ifid, input logic [31:0] idex,
                             input logic [2:0] tidex, input logic [31:0] exmem,
                             input logic [2:0] texmem, input logic [31:0] memwb,
                             input logic [2:0] tmemwb, input logic tb);
    in_t v;
    v.rst = 1'b0; v.tb = tb;
    v.ifid = ifid; v.idex = idex; v.exmem = exmem; v.memwb = memwb;
    v.tidex = tidex; v.texmem = texmem; v.tmemwb = tmemwb;
    return v;
  endfunction

  function automatic logic [4:0] m_dst(input logic [31:0] i, input logic [2:0] t);
    if (t == T_RR) return i[15:11];
    if (t == T_RM || t == T_LOAD) return i[20:16];
    return 5'd0;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src, input bit used, input in_t v);
    if (!FWD || !used || src == 5'd0) return 2'b00;
    if ((v.texmem == T_RR || v.texmem == T_RM) && m_dst(v.exmem, v.texmem) == src) return 2'b10;
    if ((v.tmemwb == T_RR || v.tmemwb == T_RM) && m_dst(v.memwb, v.tmemwb) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int m_haz(input in_t v);
    logic [4:0] rs = v.ifid[25:21];
    logic [4:0] rt = v.ifid[20:16];
    logic [4:0] d2 = (FWD && v.tidex != T_LOAD) ? 5'd0 : m_dst(v.idex, v.tidex);
    logic [4:0] d1 = (FWD && v.texmem != T_LOAD) ? 5'd0 : m_dst(v.exmem, v.texmem);
    if (d2 != 5'd0 && (d2 == rs || d2 == rt)) return 2;
    if (d1 != 5'd0 && (d1 == rs || d1 == rt)) return 1;
    return 0;
  endfunction

  // One clock: drive at negedge, sample 1ns later, check vs model, advance model.
  task automatic step(input in_t v);
    logic [1:0] efa, efb;
    bit est, efl, ehl;
    int len;
    @(negedge clk);
    rst = v.rst; TAKEN_BRANCH = v.tb;
    IF_ID_IR = v.ifid; ID_EX_IR = v.idex; EX_MEM_IR = v.exmem; MEM_WB_IR = v.memwb;
    ID_EX_TYPE = v.tidex; EX_MEM_TYPE = v.texmem; MEM_WB_TYPE = v.tmemwb;
    #1;
    efa = m_fwd(v.idex[25:21], v.tidex != T_HALT, v);
    efb = m_fwd(v.idex[20:16], v.tidex == T_RR || v.tidex == T_STORE, v);
    len = m_haz(v);
    ehl = halted; est = 1'b0; efl = 1'b0;
    if (halted) begin
      est = 1'b1;
    end else if (stall_left > 0 || drain_left > 0) begin
      if (v.tb) begin
        efl = 1'b1; stall_left = 0; drain_left = 0;
      end else begin
        est = 1'b1;
        if (stall_left > 0) stall_left--;
        else begin
          drain_left--;
          if (drain_left == 0) halted = 1'b1;
        end
      end
    end else if (v.tb) begin
      efl = 1'b1;
    end else if (v.tidex == T_HALT) begin
      est = 1'b1;
      if (DC <= 1) halted = 1'b1;
      else drain_left = DC - 1;
    end else if (len > 0) begin
      est = 1'b1;
      stall_left = len - 1;
    end
    if (v.rst) begin
      stall_left = 0; drain_left = 0; halted = 1'b0;
    end
    a_fa = ForwardA; a_fb = ForwardB; a_st = STALL; a_fl = FLUSH; a_hl = HALTED;
    chk("model_fwd_a", a_fa, efa);
    chk("model_fwd_b", a_fb, efb);
    chk("model_stall", a_st, est);
    chk("model_flush", a_fl, efl);
    chk("model_halted", a_hl, ehl);
  endtask

  function automatic logic [31:0] rnd_ir();
    return {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  function automatic logic [2:0] rnd_type();
    if ($urandom_range(0, 19) == 0) return T_HALT;
    return 3'($urandom_range(0, 4));
  endfunction

  vec_t vt[18];
  in_t  nop_in, rst_in, v;
  logic [31:0] n, cons;

  initial begin
    n      = ir(0, 0, 0);
    cons   = ir(5, 6, 7);
    nop_in = mk(n, n, T_RR, n, T_RR, n, T_RR, 1'b0);
    rst_in = nop_in;
    rst_in.rst = 1'b1;

    vt[0]  = '{mk(n, n, T_RR, n, T_RR, n, T_RR, 0), 2'b00, 2'b00, 1'b0, 1'b0};
    vt[1]  = '{mk(n, ir(3,1,8), T_RR, ir(1,2,3), T_RR, n, T_RR, 0), FWD ? 2'b10 : 2'b00, 2'b00, 1'b0, 1'b0};
    vt[2]  = '{mk(n, ir(3,1,8), T_RR, n, T_RR, ir(1,2,3), T_RR, 0), FWD ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0};
    vt[3]  = '{mk(n, ir(3,3,8), T_RR, ir(1,2,3), T_RR, ir(4,5,3), T_RR, 0), FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, 1'b0, 1'b0};
    vt[4]  = '{mk(n, ir(1,7,8), T_RR, n, T_RR, ir(2,2,7), T_RR, 0), 2'b00, FWD ? 2'b01 : 2'b00, 1'b0, 1'b0};
    vt[5]  = '{mk(ir(0,0,4), ir(0,0,8), T_RR, ir(1,1,0), T_RR, ir(1,1,0), T_RR, 0), 2'b00, 2'b00, 1'b0, 1'b0};
    vt[6]  = '{mk(n, ir(2,4,0), T_STORE, ir(1,4,0), T_RM, n, T_RR, 0), 2'b00, FWD ? 2'b10 : 2'b00, 1'b0, 1'b0};
    vt[7]  = '{mk(n, ir(4,9,0), T_RM, ir(1,1,9), T_RR, n, T_RR, 0), 2'b00, 2'b00, 1'b0, 1'b0};
    vt[8]  = '{mk(n, ir(5,0,8), T_RR, ir(1,5,0), T_LOAD, n, T_RR, 0), 2'b00, 2'b00, 1'b0, 1'b0};
    vt[9]  = '{mk(cons, ir(1,5,0), T_LOAD, n, T_RR, n, T_RR, 0), 2'b00, 2'b00, 1'b1, 1'b0};
    vt[10] = '{mk(cons, n, T_RR, ir(1,5,0), T_LOAD, n, T_RR, 0), 2'b00, 2'b00, 1'b1, 1'b0};
    vt[11] = '{mk(ir(2,3,4), ir(1,1,2), T_RR, n, T_RR, n, T_RR, 0), 2'b00, 2'b00, !FWD, 1'b0};
    vt[12] = '{mk(ir(2,3,4), n, T_RR, n, T_RR, ir(1,1,2), T_RR, 0), 2'b00, 2'b00, 1'b0, 1'b0};
    vt[13] = '{mk(ir(0,6,7), ir(1,0,0), T_LOAD, n, T_RR, n, T_RR, 0), 2'b00, 2'b00, 1'b0, 1'b0};
    vt[14] = '{mk(cons, ir(1,5,0), T_LOAD, n, T_RR, n, T_RR, 1), 2'b00, 2'b00, 1'b0, 1'b1};
    vt[15] = '{mk(ir(1,5,7), ir(1,5,0), T_LOAD, n, T_RR, n, T_RR, 0), 2'b00, 2'b00, 1'b1, 1'b0};
    vt[16] = '{mk(ir(6,0,7), n, T_RR, ir(1,6,0), T_RM, n, T_RR, 0), 2'b00, 2'b00, !FWD, 1'b0};
    vt[17] = '{mk(ir(3,0,0), ir(1,3,3), T_STORE, n, T_RR, n, T_BR, 0), 2'b00, 2'b00, 1'b0, 1'b0};

    // Power-up reset, unchecked until the state register is defined.
    rst = 1'b1; TAKEN_BRANCH = 1'b0;
    IF_ID_IR = n; ID_EX_IR = n; EX_MEM_IR = n; MEM_WB_IR = n;
    ID_EX_TYPE = T_RR; EX_MEM_TYPE = T_RR; MEM_WB_TYPE = T_RR;
    repeat (2) @(posedge clk);

    step(nop_in);
    chk("reset_stall", a_st, 0);
    chk("reset_flush", a_fl, 0);
    chk("reset_halted", a_hl, 0);
    chk("reset_fwd", {a_fa, a_fb}, 0);

    foreach (vt[i]) begin
      step(vt[i].in);
      chk($sformatf("vec%0d_fa", i), a_fa, vt[i].fa);
      chk($sformatf("vec%0d_fb", i), a_fb, vt[i].fb);
      chk($sformatf("vec%0d_stall", i), a_st, vt[i].st);
      chk($sformatf("vec%0d_flush", i), a_fl, vt[i].fl);
      step(rst_in);
    end

    // Load in ID/EX: exactly two stall cycles while the pipe advances.
    step(mk(cons, ir(1,5,0), T_LOAD, n, T_RR, n, T_RR, 0));     chk("lu2_c0", a_st, 1);
    step(mk(cons, n, T_RR, ir(1,5,0), T_LOAD, n, T_RR, 0));     chk("lu2_c1", a_st, 1);
    step(mk(cons, n, T_RR, n, T_RR, ir(1,5,0), T_LOAD, 0));     chk("lu2_c2", a_st, 0);

    // Load in EX/MEM: exactly one stall cycle.
    step(mk(cons, n, T_RR, ir(1,5,0), T_LOAD, n, T_RR, 0));     chk("lu1_c0", a_st, 1);
    step(mk(cons, n, T_RR, n, T_RR, ir(1,5,0), T_LOAD, 0));     chk("lu1_c1", a_st, 0);

    // RR producer one ahead: stall only without forwarding, selects stay 00.
    step(mk(ir(2,3,4), ir(1,1,2), T_RR, n, T_RR, n, T_RR, 0));  chk("raw_c0", a_st, !FWD);
    chk("raw_c0_fa", a_fa, 0);
    step(mk(ir(2,3,4), n, T_RR, ir(1,1,2), T_RR, n, T_RR, 0));  chk("raw_c1", a_st, !FWD);
    step(mk(ir(2,3,4), n, T_RR, n, T_RR, ir(1,1,2), T_RR, 0));  chk("raw_c2", a_st, 0);

    // HALT in EX at cycle 0: STALL from cycle 0, HALTED from cycle DC, sticky.
    step(mk(n, n, T_HALT, n, T_RR, n, T_RR, 0));
    chk("halt_c0_stall", a_st, 1); chk("halt_c0_halted", a_hl, 0);
    for (int k = 1; k < 7; k++) begin
      step(mk(n, n, T_RR, n, T_RR, n, T_RR, k == 5));
      chk($sformatf("halt_c%0d_stall", k), a_st, 1);
      chk($sformatf("halt_c%0d_halted", k), a_hl, (k >= int'(DC)) ? 1 : 0);
      chk($sformatf("halt_c%0d_flush", k), a_fl, 0);
    end
    step(rst_in);
    step(nop_in);
    chk("halt_rst_halted", a_hl, 0);
    chk("halt_rst_stall", a_st, 0);
    chk("halt_rst_flush", a_fl, 0);

    // Taken branch during LSTALL.
    step(mk(cons, ir(1,5,0), T_LOAD, n, T_RR, n, T_RR, 0));     chk("brl_c0", a_st, 1);
    step(mk(cons, n, T_RR, ir(1,5,0), T_LOAD, n, T_RR, 1));
    chk("brl_c1_flush", a_fl, 1); chk("brl_c1_stall", a_st, 0);
    step(nop_in);                                               chk("brl_c2", {a_st, a_fl}, 0);

    // Taken branch during DRAIN squashes the HALT.
    step(mk(n, n, T_HALT, n, T_RR, n, T_RR, 0));
    step(mk(n, n, T_RR, n, T_HALT, n, T_RR, 1));
    chk("brd_c1_flush", a_fl, 1); chk("brd_c1_stall", a_st, 0);
    for (int k = 2; k < 7; k++) begin
      step(nop_in);
      chk($sformatf("brd_c%0d_halted", k), a_hl, 0);
      chk($sformatf("brd_c%0d_stall", k), a_st, 0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      v.ifid = rnd_ir(); v.idex = rnd_ir(); v.exmem = rnd_ir(); v.memwb = rnd_ir();
      v.tidex = rnd_type(); v.texmem = rnd_type(); v.tmemwb = rnd_type();
      v.tb  = ($urandom_range(0, 7) == 0);
      v.rst = ($urandom_range(0, 29) == 0);
      step(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
